// File: rtl/bias_pkg.sv
// Shared types and defaults for the ping-pong bias store.
// Holds the load FSM state enum, default sizes and a lane-slice helper.
package bias_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 128;
  localparam int DEF_LANES  = 4;

  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/bias_bank_mem.sv
// One DEPTH x DATA_W bias bank: one write port, LANES registered reads.
// Ports: clk, rst_n, we/waddr/wdata, re/raddr (packed lanes), rdata.
module bias_bank_mem
  import bias_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LANES  = DEF_LANES,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    re,
  input  logic [LANES*ADDR_W-1:0] raddr,
  output logic [LANES*DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [ADDR_W-1:0] a;
    logic              hit;
    logic [DATA_W-1:0] q;

    assign a   = raddr[lane_lo(i, ADDR_W) +: ADDR_W];
    // addresses past the last entry read back as zero
    assign hit = {1'b0, a} < (ADDR_W+1)'(DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else if (re) q <= hit ? mem[a] : '0;
    end

    assign rdata[lane_lo(i, DATA_W) +: DATA_W] = q;
  end

endmodule

// File: rtl/bias_bank_pp.sv
// Double-buffered bias store: stream into shadow bank, read active bank.
// Ports: ld_* load handshake, swap/active_bank/busy, rd_* lane reads, bias.
module bias_bank_pp
  import bias_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int LANES  = DEF_LANES,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld_start,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [DATA_W-1:0]       ld_data,
  output logic                    ld_done,
  input  logic                    swap,
  output logic                    active_bank,
  output logic                    busy,
  input  logic                    rd_en,
  input  logic [LANES*ADDR_W-1:0] rd_addr,
  output logic                    rd_valid,
  output logic [LANES*DATA_W-1:0] bias
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q;
  logic                act_q;
  logic                done_q;
  logic                vld_q;
  logic                rsel_q;
  logic                fire;
  logic                last;
  logic [LANES*DATA_W-1:0] rd0, rd1;

  assign fire = ld_valid && ld_ready;
  assign last = wptr_q == ADDR_W'(DEPTH - 1);

  always_comb begin
    state_d  = state_q;
    ld_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      IDLE: if (ld_start) state_d = LOAD;
      LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        if (fire && last) state_d = FULL;
      end
      FULL: begin
        busy = 1'b1;
        if (swap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      rsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == LOAD) && fire && last;
      if (state_q == IDLE && ld_start) wptr_q <= '0;
      else if (fire) wptr_q <= wptr_q + ADDR_W'(1);
      if (state_q == FULL && swap) act_q <= ~act_q;
      vld_q <= rd_en;
      // remember which bank produced the held word
      if (rd_en) rsel_q <= act_q;
    end
  end

  bias_bank_mem #(
    .DATA_W(DATA_W), .DEPTH(DEPTH),
    .LANES(LANES), .ADDR_W(ADDR_W)
  ) u_bank0 (
    .clk(clk), .rst_n(rst_n),
    .we(fire && act_q), .waddr(wptr_q), .wdata(ld_data),
    .re(rd_en && !act_q), .raddr(rd_addr), .rdata(rd0)
  );

  bias_bank_mem #(
    .DATA_W(DATA_W), .DEPTH(DEPTH),
    .LANES(LANES), .ADDR_W(ADDR_W)
  ) u_bank1 (
    .clk(clk), .rst_n(rst_n),
    .we(fire && !act_q), .waddr(wptr_q), .wdata(ld_data),
    .re(rd_en && act_q), .raddr(rd_addr), .rdata(rd1)
  );

  assign ld_done     = done_q;
  assign active_bank = act_q;
  assign rd_valid    = vld_q;
  assign bias        = rsel_q ? rd1 : rd0;

endmodule

// File: tb/tb_bias_bank_pp.sv
// Bench for bias_bank_pp: random traffic vs a behavioural bank model.
// Second small instance covers a non-power-of-2 depth.
module tb_bias_bank_pp;

  localparam int DW = 32;
  localparam int DP = 128;
  localparam int LN = 4;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ld_start = 0, ld_valid = 0, swap = 0, rd_en = 0;
  logic [DW-1:0] ld_data = '0;
  logic [LN*AW-1:0] rd_addr = '0;
  logic          ld_ready, ld_done, active_bank, busy, rd_valid;
  logic [LN*DW-1:0] bias;

  bias_bank_pp #(.DATA_W(DW), .DEPTH(DP), .LANES(LN)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_done(ld_done), .swap(swap),
    .active_bank(active_bank), .busy(busy), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .bias(bias)
  );

  logic        s_start = 0, s_valid = 0, s_swap = 0, s_rd = 0;
  logic [15:0] s_data = '0;
  logic [13:0] s_addr = '0;
  logic        s_ready, s_done, s_act, s_busy, s_rvld;
  logic [31:0] s_bias;

  bias_bank_pp #(.DATA_W(16), .DEPTH(100), .LANES(2)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .ld_start(s_start), .ld_valid(s_valid), .ld_ready(s_ready),
    .ld_data(s_data), .ld_done(s_done), .swap(s_swap),
    .active_bank(s_act), .busy(s_busy), .rd_en(s_rd),
    .rd_addr(s_addr), .rd_valid(s_rvld), .bias(s_bias)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference: two plain arrays, a phase (0 idle,1 loading,2 full)
  logic [DW-1:0] m_mem [2][DP];
  int            m_act = 0, m_phase = 0, m_cnt = 0;
  logic [LN*DW-1:0] m_bias = '0;
  logic          m_valid = 0, m_done = 0;
  int            rdy_cycles = 0, done_pulses = 0;

  task automatic tick();
    int a;
    m_done  = 0;
    m_valid = rd_en;
    if (rd_en)
      for (int l = 0; l < LN; l++) begin
        a = int'(rd_addr[l*AW +: AW]);
        m_bias[l*DW +: DW] = (a < DP) ? m_mem[m_act][a] : '0;
      end
    if (m_phase == 0) begin
      if (ld_start) begin m_phase = 1; m_cnt = 0; end
    end else if (m_phase == 1) begin
      if (ld_valid) begin
        m_mem[1-m_act][m_cnt] = ld_data;
        m_cnt++;
        if (m_cnt == DP) begin m_phase = 2; m_done = 1; end
      end
    end else if (swap) begin
      m_act = 1 - m_act;
      m_phase = 0;
    end
    @(posedge clk);
    #1;
    chk("rd_valid", rd_valid, m_valid);
    chk("bias", bias, m_bias);
    chk("active_bank", active_bank, m_act != 0);
    chk("busy", busy, m_phase != 0);
    chk("ld_ready", ld_ready, m_phase == 1);
    chk("ld_done", ld_done, m_done);
    if (ld_ready) rdy_cycles++;
    if (ld_done) done_pulses++;
  endtask

  task automatic rand_rd();
    rd_en = 1'($urandom_range(0, 1));
    rd_addr = LN*AW'($urandom());
  endtask

  // mode 0: valid held; 1: 1-0-1-1-0 pattern; 2: random plus misuse
  task automatic run_load(input int mode, input logic [DW-1:0] base,
                          input bit rd, input int stop_at);
    int k = 0;
    int hs = 0;
    ld_start = 1;
    if (rd) rand_rd();
    tick();
    ld_start = 0;
    while (m_phase == 1 && hs < stop_at && k < 4000) begin
      unique case (mode)
        0: ld_valid = 1;
        1: ld_valid = (k % 5 != 1) && (k % 5 != 4);
        default: begin
          ld_valid = 1'($urandom_range(0, 1));
          swap = 1'($urandom_range(0, 1));
          ld_start = 1'($urandom_range(0, 1));
        end
      endcase
      ld_data = base + DW'(hs);
      if (rd) rand_rd();
      if (ld_valid) hs++;
      tick();
      k++;
    end
    ld_valid = 0;
    swap = 0;
    ld_start = 0;
    rd_en = 0;
    if (stop_at >= DP) chk("load_handshakes", hs, DP);
  endtask

  task automatic sweep();
    for (int a = 0; a < DP / LN; a++) begin
      rd_en = 1;
      for (int l = 0; l < LN; l++)
        rd_addr[l*AW +: AW] = AW'(a * LN + l);
      tick();
    end
    rd_en = 0;
    tick();
  endtask

  task automatic do_swap(input bit rd);
    swap = 1;
    if (rd) rand_rd();
    tick();
    swap = 0;
    if (rd) begin rand_rd(); rd_en = 1; tick(); end
    rd_en = 0;
  endtask

  initial begin
    int hs;
    int guard;
    bit got;
    bit fire;

    #2;
    chk("rst_state", {ld_ready, ld_done, rd_valid, busy, active_bank}, '0);
    chk("rst_bias", bias, '0);
    @(posedge clk);
    #1 rst_n = 1;

    // 1: straight load then swap, fixed read
    rdy_cycles = 0;
    done_pulses = 0;
    run_load(0, 32'h1000, 0, DP);
    chk("ready_cycles", rdy_cycles, DP);
    chk("done_pulses", done_pulses, 1);
    do_swap(0);
    chk("active_after_swap", active_bank, 1);
    rd_en = 1;
    rd_addr = {7'd64, 7'd127, 7'd5, 7'd0};
    tick();
    rd_en = 0;
    chk("t1_rd_valid", rd_valid, 1);
    chk("t1_bias", bias, {32'h1040, 32'h107F, 32'h1005, 32'h1000});
    tick();
    chk("t1_rd_valid_drop", rd_valid, 0);
    chk("t1_bias_hold", bias, {32'h1040, 32'h107F, 32'h1005, 32'h1000});

    // 2: ping-pong, reading throughout
    run_load(0, 32'hFFFFF000, 1, DP);
    do_swap(1);
    sweep();

    // 3: backpressure pattern
    done_pulses = 0;
    run_load(1, DW'($urandom()), 1, DP);
    chk("t3_done_pulses", done_pulses, 1);
    do_swap(1);
    sweep();

    // 4: misuse in every state
    swap = 1; tick(); tick(); swap = 0;
    run_load(2, DW'($urandom()), 1, DP);
    ld_start = 1; tick(); tick(); ld_start = 0;
    chk("t4_still_full", busy, 1);
    do_swap(1);
    sweep();

    // 5: reset mid-load
    run_load(0, 32'h5A5A0000, 0, 40);
    #2 rst_n = 0;
    #1;
    chk("t5_rst_outs",
        {ld_ready, ld_done, rd_valid, busy, active_bank}, '0);
    chk("t5_rst_bias", bias, '0);
    m_phase = 0; m_act = 0; m_bias = '0;
    @(negedge clk);
    rst_n = 1;
    do_swap(0);
    chk("t5_active", active_bank, 0);
    sweep();

    // 6: DEPTH=100, LANES=2, DATA_W=16
    @(posedge clk);
    #1 s_start = 1;
    @(posedge clk);
    #1 s_start = 0;
    hs = 0; guard = 0; got = 0;
    while (!got && guard < 1000) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data = 16'hA000 + 16'(hs);
      fire = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (fire) hs++;
      if (s_done) begin
        got = 1;
        chk("t6_done_at", hs, 100);
      end
      guard++;
    end
    s_valid = 0;
    chk("t6_done_seen", got, 1);
    s_swap = 1;
    @(posedge clk);
    #1 s_swap = 0;
    chk("t6_active", s_act, 1);
    s_rd = 1;
    s_addr = {7'd100, 7'd99};
    @(posedge clk);
    #1;
    chk("t6_rvld", s_rvld, 1);
    chk("t6_addr99_100", s_bias, {16'h0000, 16'hA063});
    s_addr = {7'd127, 7'd0};
    @(posedge clk);
    #1;
    chk("t6_addr0_127", s_bias, {16'h0000, 16'hA000});
    s_addr = {7'd50, 7'd98};
    @(posedge clk);
    #1 s_rd = 0;
    chk("t6_addr98_50", s_bias, {16'hA032, 16'hA062});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
